// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with 8-word lines and a
// single outstanding fetch; misses refill a whole line from memory in word order.
module inst_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        from_cpu_inst_req_valid,
    input  logic [31:0] from_cpu_inst_req_addr,
    output logic        to_cpu_inst_req_ready,
    output logic        to_cpu_cache_rsp_valid,
    output logic [31:0] to_cpu_cache_rsp_data,
    input  logic        from_cpu_cache_rsp_ready,
    output logic        to_mem_rd_req_valid,
    output logic [31:0] to_mem_rd_req_addr,
    input  logic        from_mem_rd_req_ready,
    input  logic        from_mem_rd_rsp_valid,
    input  logic [31:0] from_mem_rd_rsp_data,
    input  logic        from_mem_rd_rsp_last,
    output logic        to_mem_rd_rsp_ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 27 - INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_REQ,
        S_REFILL,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [31:0]       r_addr;
    logic [2:0]        r_beat_cnt;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag_array [LINES];
    logic [31:0]       r_data_array [LINES*8];
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_data;
    logic              r_mem_req_valid;
    logic              r_mem_rsp_ready;
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [2:0]            w_offset;
    logic                  w_hit;
    logic                  w_beat_fire;
    logic                  w_unused;

    assign w_index     = r_addr[4+INDEX_BITS:5];
    assign w_tag       = r_addr[31:5+INDEX_BITS];
    assign w_offset    = r_addr[4:2];
    assign w_hit       = r_valid[w_index] && (r_tag_array[w_index] == w_tag);
    assign w_beat_fire = (r_state == S_REFILL) && from_mem_rd_rsp_valid;
    assign w_unused    = ^r_addr[1:0];

    assign to_cpu_inst_req_ready  = r_req_ready;
    assign to_cpu_cache_rsp_valid = r_rsp_valid;
    assign to_cpu_cache_rsp_data  = r_rsp_data;
    assign to_mem_rd_req_valid    = r_mem_req_valid;
    assign to_mem_rd_req_addr     = {r_addr[31:5], 5'b0};
    assign to_mem_rd_rsp_ready    = r_mem_rsp_ready;
    assign hit_cnt                = r_hit_cnt;
    assign miss_cnt               = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_valid         <= '0;
            r_beat_cnt      <= 3'd0;
            r_hit_cnt       <= 32'd0;
            r_miss_cnt      <= 32'd0;
            r_req_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_rsp_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (from_cpu_inst_req_valid) begin
                        r_addr      <= from_cpu_inst_req_addr;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_hit_cnt   <= r_hit_cnt + 32'd1;
                        r_rsp_data  <= r_data_array[{w_index, w_offset}];
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_miss_cnt      <= r_miss_cnt + 32'd1;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    // The victim is invalidated up front so a partly refilled line never looks valid.
                    if (from_mem_rd_req_ready) begin
                        r_mem_req_valid  <= 1'b0;
                        r_mem_rsp_ready  <= 1'b1;
                        r_beat_cnt       <= 3'd0;
                        r_valid[w_index] <= 1'b0;
                        r_state          <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (from_mem_rd_rsp_valid) begin
                        r_beat_cnt <= r_beat_cnt + 3'd1;
                        // Capture the requested word as it streams past, so offset 7 needs no extra cycle.
                        if (r_beat_cnt == w_offset) begin
                            r_rsp_data <= from_mem_rd_rsp_data;
                        end
                        if (from_mem_rd_rsp_last) begin
                            r_valid[w_index] <= 1'b1;
                            r_mem_rsp_ready  <= 1'b0;
                            r_rsp_valid      <= 1'b1;
                            r_state          <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (from_cpu_cache_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat_fire) begin
            r_data_array[{w_index, r_beat_cnt}] <= from_mem_rd_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat_fire && from_mem_rd_rsp_last) begin
            r_tag_array[w_index] <= w_tag;
        end
    end
endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: a line-level cache/memory model predicts hits, data,
// refill addresses and counters; directed fetches pin the model with literals.
module tb_inst_cache;
    localparam int SETS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        from_cpu_inst_req_valid;
    logic [31:0] from_cpu_inst_req_addr;
    logic        to_cpu_inst_req_ready;
    logic        to_cpu_cache_rsp_valid;
    logic [31:0] to_cpu_cache_rsp_data;
    logic        from_cpu_cache_rsp_ready;
    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready;
    logic        from_mem_rd_rsp_valid;
    logic [31:0] from_mem_rd_rsp_data;
    logic        from_mem_rd_rsp_last;
    logic        to_mem_rd_rsp_ready;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    inst_cache #(.INDEX_BITS(3)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
        .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
        .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
        .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
        .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
        .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
        .to_mem_rd_req_valid      (to_mem_rd_req_valid),
        .to_mem_rd_req_addr       (to_mem_rd_req_addr),
        .from_mem_rd_req_ready    (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready),
        .hit_cnt                  (hit_cnt),
        .miss_cnt                 (miss_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    bit          model_valid [SETS];
    logic [31:0] model_tag   [SETS];
    logic [31:0] model_hits   = 32'd0;
    logic [31:0] model_misses = 32'd0;
    logic [31:0] exp_data = 32'd0;
    logic [31:0] exp_line = 32'd0;
    bit          exp_miss = 1'b0;
    bit          cpu_busy = 1'b0;
    bit          refill_active = 1'b0;
    bit          chk_en = 1'b0;

    // Memory responder controls
    int          mem_stall   = 0;
    int          beat_gap    = 0;
    int          abort_beats = -1;
    bit          abort_done  = 1'b0;
    int          mem_reqs    = 0;
    logic [31:0] mem_last_line = 32'hFFFF_FFFF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 5) % SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return model_valid[set_of(a)] && (model_tag[set_of(a)] == (a >> 8));
    endfunction

    // Memory word at byte address a
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h13;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) model_valid[i] = 1'b0;
        model_hits   = 32'd0;
        model_misses = 32'd0;
        cpu_busy     = 1'b0;
        refill_active = 1'b0;
    endtask

    // Compare process
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                chk("req_ready", 32'(to_cpu_inst_req_ready), 32'(!cpu_busy));
                chk("mem_rsp_ready", 32'(to_mem_rd_rsp_ready), 32'(refill_active));
                chk("hit_cnt", hit_cnt, model_hits);
                chk("miss_cnt", miss_cnt, model_misses);
                chk("rsp_gate", 32'(to_cpu_cache_rsp_valid & ~cpu_busy), 32'd0);
                chk("mem_req_gate", 32'(to_mem_rd_req_valid & ~(exp_miss & cpu_busy)), 32'd0);
                if (to_cpu_cache_rsp_valid) chk("rsp_data", to_cpu_cache_rsp_data, exp_data);
                if (to_mem_rd_req_valid) chk("mem_req_addr", to_mem_rd_req_addr, exp_line);
            end
        end
    end

    // Memory responder
    initial begin
        logic pre;
        from_mem_rd_req_ready = 1'b0;
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_data  = 32'd0;
        from_mem_rd_rsp_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en && to_mem_rd_req_valid === 1'b1) begin
                mem_last_line = to_mem_rd_req_addr;
                repeat (mem_stall) @(negedge clk);
                from_mem_rd_req_ready = 1'b1;
                @(posedge clk);
                refill_active = 1'b1;
                mem_reqs++;
                @(negedge clk);
                from_mem_rd_req_ready = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    if (b == abort_beats) begin
                        abort_done = 1'b1;
                        break;
                    end
                    if (b > 0) repeat (beat_gap) @(negedge clk);
                    from_mem_rd_rsp_valid = 1'b1;
                    from_mem_rd_rsp_data  = mem_word(mem_last_line + 32'(4 * b));
                    from_mem_rd_rsp_last  = (b == 7);
                    pre = to_cpu_cache_rsp_valid;
                    @(posedge clk);
                    if (b == 7) begin
                        refill_active = 1'b0;
                        #1;
                        chk("miss_rsp_one_cycle", 32'({pre, to_cpu_cache_rsp_valid}), 32'b01);
                    end
                    @(negedge clk);
                    from_mem_rd_rsp_valid = 1'b0;
                    from_mem_rd_rsp_last  = 1'b0;
                end
            end
        end
    end

    // One fetch: handshake, wait for response (or refill abort), optional backpressure.
    task automatic fetch(input logic [31:0] a, input int bp, input bit abort,
                         output logic [31:0] got, output int lat, output int mlat);
        bit hit;
        int n;
        hit      = model_hit(a);
        exp_data = mem_word(a);
        exp_line = {a[31:5], 5'b0};
        exp_miss = !hit;
        got  = 32'hDEAD_BEEF;
        lat  = -1;
        mlat = -1;
        @(negedge clk);
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr  = a;
        chk("req_ready_at_issue", 32'(to_cpu_inst_req_ready), 32'd1);
        @(posedge clk);
        cpu_busy = 1'b1;
        #1 from_cpu_inst_req_valid = 1'b0;
        for (n = 1; n <= 300; n++) begin
            @(posedge clk);
            if (n == 1) begin
                if (hit) model_hits = model_hits + 32'd1;
                else     model_misses = model_misses + 32'd1;
            end
            #1;
            if (mlat < 0 && to_mem_rd_req_valid) mlat = n + 1;
            if (abort ? abort_done : to_cpu_cache_rsp_valid) break;
        end
        if (n > 300) begin
            total++;
            bad++;
            $display("FAIL wait_budget: no response for addr %h within %0d cycles", a, n - 1);
        end
        lat = n + 1;
        if (abort) return;
        got = to_cpu_cache_rsp_data;
        repeat (bp) @(posedge clk);
        @(negedge clk);
        from_cpu_cache_rsp_ready = 1'b1;
        @(posedge clk);
        cpu_busy = 1'b0;
        if (!hit) begin
            model_valid[set_of(a)] = 1'b1;
            model_tag[set_of(a)]   = a >> 8;
        end
        #1 from_cpu_cache_rsp_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"}, 32'(to_cpu_inst_req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(to_cpu_cache_rsp_valid), 32'd0);
        chk({tag, "_mem_req_valid"}, 32'(to_mem_rd_req_valid), 32'd0);
        chk({tag, "_mem_rsp_ready"}, 32'(to_mem_rd_rsp_ready), 32'd0);
        chk({tag, "_hit_cnt"}, hit_cnt, 32'd0);
        chk({tag, "_miss_cnt"}, miss_cnt, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int lat, mlat, reqs0;
        rst = 1'b1;
        from_cpu_inst_req_valid  = 1'b0;
        from_cpu_inst_req_addr   = 32'd0;
        from_cpu_cache_rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Cold miss on line 0
        reqs0 = mem_reqs;
        fetch(32'h0000_0000, 0, 1'b0, got, lat, mlat);
        chk("cold_data", got, 32'h0000_0013);
        chk("cold_mem_addr", mem_last_line, 32'h0000_0000);
        chk("cold_mem_req_lat", 32'(mlat), 32'd2);
        chk("cold_miss_cnt", miss_cnt, 32'd1);
        chk("cold_mem_reqs", 32'(mem_reqs), 32'(reqs0 + 1));

        // Hit, last word of line 0
        reqs0 = mem_reqs;
        fetch(32'h0000_001C, 0, 1'b0, got, lat, mlat);
        chk("hit_data", got, 32'h0000_002F);
        chk("hit_lat", 32'(lat), 32'd2);
        chk("hit_no_mem", 32'(mem_reqs), 32'(reqs0));
        chk("hit_cnt_1", hit_cnt, 32'd1);

        // Conflict on set 0, then the evicted line misses again
        fetch(32'h0000_0100, 0, 1'b0, got, lat, mlat);
        chk("conf_data", got, 32'h0000_0113);
        chk("conf_mem_addr", mem_last_line, 32'h0000_0100);
        fetch(32'h0000_0000, 0, 1'b0, got, lat, mlat);
        chk("reload_data", got, 32'h0000_0013);
        chk("reload_miss_cnt", miss_cnt, 32'd3);
        chk("reload_mem_reqs", 32'(mem_reqs), 32'(reqs0 + 2));

        // Response backpressure for 5 cycles
        fetch(32'h0000_0004, 5, 1'b0, got, lat, mlat);
        chk("bp_data", got, 32'h0000_0017);
        chk("bp_hit_cnt", hit_cnt, 32'd2);

        // Stalled memory, gapped beats, offset 7 on the last beat
        mem_stall = 4;
        beat_gap  = 2;
        fetch(32'h0000_02DC, 0, 1'b0, got, lat, mlat);
        chk("stall_data", got, 32'h0000_02EF);
        chk("stall_mem_addr", mem_last_line, 32'h0000_02C0);
        mem_stall = 0;
        beat_gap  = 0;
        for (int i = 0; i < 8; i++) begin
            fetch(32'h0000_02C0 + 32'(4 * i), 0, 1'b0, got, lat, mlat);
            chk("stall_word", got, 32'h0000_02D3 + 32'(4 * i));
        end
        chk("stall_hit_cnt", hit_cnt, 32'd10);

        // Reset after four beats of a refill
        abort_beats = 4;
        fetch(32'h0000_0340, 0, 1'b1, got, lat, mlat);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_reset_state("abort");
        @(negedge clk);
        rst = 1'b0;
        abort_beats = -1;
        abort_done  = 1'b0;
        chk_en = 1'b1;

        reqs0 = mem_reqs;
        fetch(32'h0000_0340, 0, 1'b0, got, lat, mlat);
        chk("rerq_data", got, 32'h0000_0353);
        chk("rerq_miss_cnt", miss_cnt, 32'd1);
        chk("rerq_mem_reqs", 32'(mem_reqs), 32'(reqs0 + 1));
        fetch(32'h0000_035C, 0, 1'b0, got, lat, mlat);
        chk("rerq_last_word", got, 32'h0000_036F);
        chk("rerq_hit_cnt", hit_cnt, 32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
